// File: rtl/ks_adder_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Smallest r with 2**r >= value (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 32'sd1) / den;
    endfunction

endpackage

// File: rtl/ks_adder_pipe_black_cell.sv
// Kogge-Stone black cell: merges a high group (P_hi, G_hi) with the adjacent lower group.
module ks_black_cell (
    input  logic P_hi,
    input  logic G_hi,
    input  logic P_lo,
    input  logic G_lo,
    output logic P,
    output logic G
);

    assign P = P_hi & P_lo;
    assign G = G_hi | (P_hi & G_lo);

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake, global stall,
// sideband tag and carry/overflow/zero flags.
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int N          = 32,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);

    localparam int LOG2N = clog2(N);
    localparam int G     = ceil_div(LOG2N, PIPE_EVERY);

    // Index 0 is the input register; index s holds the prefix groups after stage s.
    logic [N-1:0]     r_grp_p [0:G];
    logic [N-1:0]     r_grp_g [0:G];
    logic [N-1:0]     r_bit_p [0:G];
    logic             r_c0    [0:G];
    logic             r_a_msb [0:G];
    logic             r_vld   [0:G];
    logic [TAG_W-1:0] r_tag   [0:G];

    logic [N-1:0]     w_stage_p [1:G];
    logic [N-1:0]     w_stage_g [1:G];

    logic             r_out_valid;
    logic [N-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [TAG_W-1:0] r_tag_out;

    logic             w_stall;
    logic             w_accept;
    logic [N-1:0]     w_b_eff;
    logic             w_c0;
    logic [N:0]       w_carry;
    logic [N-1:0]     w_sum;
    logic             w_ovf;
    logic             w_zero;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && !w_stall;
    assign w_b_eff  = (sub == OP_SUB) ? ~b : b;
    assign w_c0     = (sub == OP_SUB) ? 1'b1 : cin;

    // Level k merges groups at distance 2**(k-1); the first level of each stage reads the previous stage register.
    for (genvar k = 1; k <= LOG2N; k++) begin : g_lvl
        localparam int S = (k - 1) / PIPE_EVERY + 1;
        localparam int D = 1 << (k - 1);
        logic [N-1:0] w_src_p;
        logic [N-1:0] w_src_g;
        logic [N-1:0] w_lvl_p;
        logic [N-1:0] w_lvl_g;

        if (((k - 1) % PIPE_EVERY) == 0) begin : g_from_reg
            assign w_src_p = r_grp_p[S-1];
            assign w_src_g = r_grp_g[S-1];
        end else begin : g_from_lvl
            assign w_src_p = g_lvl[k-1].w_lvl_p;
            assign w_src_g = g_lvl[k-1].w_lvl_g;
        end

        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i < D) begin : g_pass
                assign w_lvl_p[i] = w_src_p[i];
                assign w_lvl_g[i] = w_src_g[i];
            end else begin : g_black
                ks_black_cell u_cell (
                    .P_hi (w_src_p[i]),
                    .G_hi (w_src_g[i]),
                    .P_lo (w_src_p[i-D]),
                    .G_lo (w_src_g[i-D]),
                    .P    (w_lvl_p[i]),
                    .G    (w_lvl_g[i])
                );
            end
        end
    end

    for (genvar s = 1; s <= G; s++) begin : g_stg
        localparam int LK = ((s * PIPE_EVERY) < LOG2N) ? (s * PIPE_EVERY) : LOG2N;
        assign w_stage_p[s] = g_lvl[LK].w_lvl_p;
        assign w_stage_g[s] = g_lvl[LK].w_lvl_g;
    end

    // Input register plus prefix stage registers; everything freezes while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= G; s++) begin
                r_grp_p[s] <= {N{1'b0}};
                r_grp_g[s] <= {N{1'b0}};
                r_bit_p[s] <= {N{1'b0}};
                r_c0[s]    <= 1'b0;
                r_a_msb[s] <= 1'b0;
                r_vld[s]   <= 1'b0;
                r_tag[s]   <= {TAG_W{1'b0}};
            end
        end else if (!w_stall) begin
            r_vld[0] <= in_valid;
            if (w_accept) begin
                r_grp_p[0] <= a ^ w_b_eff;
                r_grp_g[0] <= a & w_b_eff;
                r_bit_p[0] <= a ^ w_b_eff;
                r_c0[0]    <= w_c0;
                r_a_msb[0] <= a[N-1];
                r_tag[0]   <= tag_in;
            end
            for (int s = 1; s <= G; s++) begin
                r_grp_p[s] <= w_stage_p[s];
                r_grp_g[s] <= w_stage_g[s];
                r_bit_p[s] <= r_bit_p[s-1];
                r_c0[s]    <= r_c0[s-1];
                r_a_msb[s] <= r_a_msb[s-1];
                r_vld[s]   <= r_vld[s-1];
                r_tag[s]   <= r_tag[s-1];
            end
        end
    end

    // Carries from the completed prefix groups, then sum and status flags.
    always_comb begin
        w_carry    = {(N+1){1'b0}};
        w_carry[0] = r_c0[G];
        for (int i = 0; i < N; i++) begin
            w_carry[i+1] = r_grp_g[G][i] | (r_grp_p[G][i] & r_c0[G]);
        end
        w_sum  = r_bit_p[G] ^ w_carry[N-1:0];
        // Equal operand MSBs show up as a zero bitwise propagate bit.
        w_ovf  = !r_bit_p[G][N-1] && (w_sum[N-1] != r_a_msb[G]);
        w_zero = (w_sum == {N{1'b0}});
    end

    // Output register; data only loads with a valid result so it stays put between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= {N{1'b0}};
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_tag_out   <= {TAG_W{1'b0}};
        end else if (!w_stall) begin
            r_out_valid <= r_vld[G];
            if (r_vld[G]) begin
                r_sum     <= w_sum;
                r_cout    <= w_carry[N];
                r_ovf     <= w_ovf;
                r_zero    <= w_zero;
                r_tag_out <= r_tag[G];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed and streaming checks for ks_adder_pipe (N=32/PIPE_EVERY=2 and N=8/PIPE_EVERY=1).
module tb_ks_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, ovf, zero;
    logic [3:0]  tag_in, tag_out;

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready;
    logic [7:0]  e_a, e_b, e_sum;
    logic        e_cin, e_sub, e_cout, e_ovf, e_zero;
    logic [3:0]  e_tag_in, e_tag_out;

    ks_adder_pipe #(.N(32), .PIPE_EVERY(2), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .zero(zero), .tag_out(tag_out)
    );

    ks_adder_pipe #(.N(8), .PIPE_EVERY(1), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .a(e_a), .b(e_b), .cin(e_cin), .sub(e_sub), .tag_in(e_tag_in),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .sum(e_sum), .cout(e_cout),
        .ovf(e_ovf), .zero(e_zero), .tag_out(e_tag_out)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [3:0]  tag;
        logic [31:0] esum;
        logic        ecout;
        logic        eovf;
        logic        ezero;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] obs32();
        return {tag_out, ovf, zero, cout, sum};
    endfunction

    // Reference: plain wide addition of the effective operands.
    function automatic logic [38:0] model(input logic [31:0] fa, input logic [31:0] fb,
                                          input logic fcin, input logic fsub, input logic [3:0] ftag);
        logic [31:0] be;
        logic        c0;
        logic [32:0] r;
        logic        fovf;
        logic        fzero;
        be    = fsub ? ~fb : fb;
        c0    = fsub ? 1'b1 : fcin;
        r     = {1'b0, fa} + {1'b0, be} + {32'd0, c0};
        fovf  = (fa[31] == be[31]) && (r[31] != fa[31]);
        fzero = (r[31:0] == 32'd0);
        return {ftag, fovf, fzero, r[32], r[31:0]};
    endfunction

    // Issue one operation on the 32-bit DUT and check latency and result.
    task automatic run_one(input vec_t v, input string nm);
        int lat;
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; tag_in = v.tag;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, 64'(lat), 64'd4);
        check({nm, " result"}, 64'(obs32()), 64'({v.tag, v.eovf, v.ezero, v.ecout, v.esum}));
        @(posedge clk); #1;
    endtask

    task automatic stream(input bit rand_ready, input string nm);
        logic [38:0] q[$];
        logic [38:0] exp_r;
        logic [38:0] held;
        bit          held_stall;
        bit          accepted;
        int          sent, rcvd, cyc, last_rx;
        sent = 0; rcvd = 0; cyc = 0; last_rx = -1;
        held_stall = 1'b0; accepted = 1'b0; held = '0;
        in_valid = 1'b0;
        while ((sent < 100 || rcvd < 100) && cyc < 3000) begin
            if (held_stall) check({nm, " hold"}, 64'(obs32()), 64'(held));
            if (accepted) in_valid = 1'b0;
            accepted = 1'b0;
            if (sent < 100 && !in_valid) begin
                a = $urandom; b = $urandom;
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                tag_in = sent[3:0];
                in_valid = 1'b1;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check({nm, " in_ready"}, 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL %s extra: got unexpected result 0x%0h, required none", nm, obs32());
                end else begin
                    exp_r = q.pop_front();
                    check({nm, " result"}, 64'(obs32()), 64'(exp_r));
                end
                if (!rand_ready && last_rx >= 0) check({nm, " throughput gap"}, 64'(cyc - last_rx), 64'd1);
                last_rx = cyc;
                rcvd++;
            end
            held_stall = out_valid && !out_ready;
            held = obs32();
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub, tag_in));
                sent++;
                accepted = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check({nm, " received"}, 64'(rcvd), 64'd100);
        check({nm, " leftover"}, 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        vecs[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'h1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 4'h2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'h3, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h4, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 4'h5, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 4'h6, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h00000001, 32'h00000001, 1'b1, 1'b1, 4'h7, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'h8, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 4'h9, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'hA, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 4'hB, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag_in = '0;
        e_in_valid = 1'b0; e_out_ready = 1'b1; e_a = '0; e_b = '0; e_cin = 1'b0; e_sub = 1'b0; e_tag_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset outputs", 64'(obs32()), 64'd0);
        check("reset out_valid n8", 64'(e_out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);

        // N=8, PIPE_EVERY=1 single operation
        e_a = 8'h5A; e_b = 8'h3C; e_cin = 1'b0; e_sub = 1'b0; e_tag_in = 4'h3; e_in_valid = 1'b1;
        @(posedge clk); #1;
        e_in_valid = 1'b0;
        lat = 0;
        while (!e_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("n8 latency", 64'(lat), 64'd4);
        check("n8 result", 64'({e_tag_out, e_ovf, e_zero, e_cout, e_sum}),
              64'({4'h3, 1'b1, 1'b0, 1'b0, 8'h96}));
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
        end

        stream(1'b0, "stream_ready");
        stream(1'b1, "stream_toggle");

        // Reset with three results in flight
        run_one(vecs[10], "pre_reset");
        for (int i = 0; i < 3; i++) begin
            a = 32'h1000 + 32'(i); b = 32'h22; cin = 1'b0; sub = 1'b0; tag_in = 4'(i + 1);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("inflight out_valid", 64'(out_valid), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset outputs", 64'(obs32()), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready post reset", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("no stale result %0d", i), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor. It is the successor to the fixed 8-bit combinational prefix adder.
- Width is generic (power of two). Prefix levels are grouped into register stages, and the block adds an add/sub mode plus status flags.
- Sits in the datapath between a valid/ready producer (operand issue) and a valid/ready consumer (result writeback).
- Results stay in order. A single global stall provides backpressure.

Parameters:
- N, 32, operand width. Power of two, 2 to 128. LOG2N = log2(N) prefix levels.
- PIPE_EVERY, 2, prefix levels per register stage. Range 1 to LOG2N. G = ceil(LOG2N/PIPE_EVERY).
- TAG_W, 4, width of the sideband tag carried alongside the operands.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, block can accept operands this cycle.
- a, input, N, operand A.
- b, input, N, operand B.
- cin, input, 1, carry-in. Used only when sub=0.
- sub, input, 1, 0 = A+B+cin; 1 = A-B (A + ~B + 1).
- tag_in, input, TAG_W, sideband tag, passed through unchanged.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- sum, output, N, result bits [N-1:0].
- cout, output, 1, carry out of bit N-1. For sub this is the no-borrow flag.
- ovf, output, 1, signed overflow: (a_eff[N-1]==b_eff[N-1]) && (sum[N-1]!=a_eff[N-1]), where b_eff is B after the optional inversion and a_eff is A.
- zero, output, 1, sum == 0.
- tag_out, output, TAG_W, tag of the current result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits = 0, so out_valid = 0.
  - sum, cout, ovf, zero, tag_out = 0. All pipeline data registers = 0.
  - in_ready = 1 from the first cycle after reset deassertion.
  - Reset mid-operation discards all in-flight results. No output is produced for them.
- Stage 0 (input register):
  - Captures a, b_eff = sub ? ~b : b, c0 = sub ? 1 : cin, and tag.
  - Captures when in_valid && in_ready.
  - Bitwise p = a ^ b_eff and g = a & b_eff are computed before the register.
- Stages 1..G:
  - Each stage evaluates up to PIPE_EVERY Kogge-Stone levels. Level k uses distance 2^(k-1).
  - At bit positions i < 2^(k-1), the cell passes P and G through unchanged (identity: P=1, G=0 neighbour).
  - Bitwise p and c0 ride along with each stage.
  - The final stage computes C[i+1] = G[i] | (P[i] & c0), sum[i] = p[i] ^ C[i] with C[0] = c0, cout = C[N], ovf and zero. It then registers them into the output register.
- Latency:
  - Exactly LAT = 1 + G cycles from the accepting edge to out_valid, with no stall.
  - Examples: N=32, PIPE_EVERY=2 gives LAT=4. N=8, PIPE_EVERY=1 gives LAT=4.
- Throughput: one result per cycle when out_ready is held high.
- Stall and handshake:
  - stall = out_valid && !out_ready. All stage registers hold when stall = 1. in_ready = !stall.
  - Bubbles are not collapsed during a stall.
  - While out_valid is high, sum, cout, ovf, zero and tag_out stay stable until out_ready is seen.
  - Simultaneous in_valid and stall: the input is not accepted, and the producer must hold it.
  - out_ready while out_valid = 0 has no effect.
- Arithmetic:
  - Modulo 2^N. No saturation.
  - cin is ignored when sub=1.
  - Carry chain wrap: a = all ones, b = 0, cin = 1 gives sum = 0, cout = 1, zero = 1.

Decomposition:
- Shared package ks_pkg holds:
  - the clog2 function and the ceil-divide used for G;
  - the opcode constants OP_ADD=1'b0 and OP_SUB=1'b1.
- One sub-module, ks_black_cell (inputs P_hi, G_hi, P_lo, G_lo; outputs P = P_hi & P_lo and G = G_hi | (P_hi & G_lo)).
- The identity (pass-through) case is handled in the generate loop, not in a separate cell.

Test Plan:
- N=8, PIPE_EVERY=1, with a single input 0x5A+0x3C, cin=0, sub=0 and tag 0x3. Expect out_valid exactly 4 cycles later with sum=0x96, cout=0, ovf=1, zero=0, tag_out=0x3.
- N=32, PIPE_EVERY=2, with 0xFFFFFFFF+0x00000000 and cin=1. Expect sum=0x00000000, cout=1, zero=1, ovf=0, at latency 4.
- N=32, sub=1: 5-7 gives sum=0xFFFFFFFE, cout=0; 0x80000000-1 gives sum=0x7FFFFFFF, ovf=1, cout=1.
- Back-to-back stream of 100 random operand pairs, out_ready=1. Expect one result per cycle, in order, with tags matching and results matching the reference model.
- Same random stream with out_ready toggling randomly:
  - in_ready equals !(out_valid && !out_ready) on every cycle;
  - outputs are held stable while stalled;
  - no result is lost or duplicated.
- Pulse rst_n low for 1 cycle while 3 results are in flight. Expect out_valid=0 and all outputs 0 immediately. No stale result may emerge afterwards, and in_ready=1 on the next cycle.
